dom_data_transmission: RTL and testbench

DOM_DATA_TRANSMISSION -- requirements
Module: dom_data_transmission

---
 rtl/dom_data_transmission_if.sv | 21 ++
 rtl/dom_data_transmission.sv | 109 ++++++++++
 tb/tb_dom_data_transmission.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dom_data_transmission_if.sv
// rtl/dom_data_transmission_if.sv - user/receiver signal bundle for the paced byte transmitter
interface dom_data_transmission_if;
  logic       send_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       empty_o;
  logic       full_o;
  logic [3:0] tx_count_o;

  modport master (
    output send_i, data_i,
    input  ready_o, valid_o, data_o, empty_o, full_o, tx_count_o
  );

  modport slave (
    input  send_i, data_i,
    output ready_o, valid_o, data_o, empty_o, full_o, tx_count_o
  );
endinterface

// File: rtl/dom_data_transmission.sv
// rtl/dom_data_transmission.sv - FIFO-buffered byte transmitter with fixed idle gap between strobes
module dom_data_transmission #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  dom_data_transmission_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    gap_q, gap_d;
  logic          launch;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, push;

  logic          valid_q;
  logic [7:0]    data_q;
  logic [3:0]    tx_count_q;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // Full blocks the push even if a pop lands on the same edge.
  assign push  = bus.send_i && !full;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          launch  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        gap_d   = 4'(GAP - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // At gap zero with data pending, launch straight away so pulses stay GAP+1 apart.
        if (gap_q == 4'd0) begin
          if (!empty) begin
            launch  = 1'b1;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      gap_q      <= 4'd0;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
      tx_count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= launch;
      if (launch) begin
        data_q     <= mem[rd_ptr];
        tx_count_q <= tx_count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (launch) rd_ptr <= rd_ptr + AW'(1);
      case ({push, launch})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= bus.data_i;
  end

  assign bus.ready_o    = !full;
  assign bus.valid_o    = valid_q;
  assign bus.data_o     = data_q;
  assign bus.empty_o    = empty;
  assign bus.full_o     = full;
  assign bus.tx_count_o = tx_count_q;
endmodule

// File: tb/tb_dom_data_transmission.sv
// tb/tb_dom_data_transmission.sv - scoreboard bench for dom_data_transmission
module tb_dom_data_transmission;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dom_data_transmission_if bus();

  dom_data_transmission #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb[$];
  int         m_count = 0;
  logic [3:0] exp_tx = 4'd0;
  logic [7:0] last_data = 8'd0;
  int         cyc = 0;
  int         prev_cyc = 0;
  bit         have_prev = 0;
  bit         pend_prev = 0;
  bit         prev_valid = 0;
  bit         saw_full = 0;
  int         rejected = 0;
  int         acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [7:0] exp_byte;
    if (bus.valid_o) begin
      check("no_back_to_back", 32'(prev_valid), 32'd0);
      if (have_prev) begin
        if (pend_prev) check("spacing", 32'(cyc - prev_cyc), 32'(GAP + 1));
        else           check("min_spacing", 32'((cyc - prev_cyc) >= GAP + 1), 32'd1);
      end
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_byte = sb.pop_front();
        check("data_o", 32'(bus.data_o), 32'(exp_byte));
        last_data = exp_byte;
        m_count--;
      end
      exp_tx = exp_tx + 4'd1;
      check("tx_count", 32'(bus.tx_count_o), 32'(exp_tx));
      pend_prev = (sb.size() != 0);
      prev_cyc  = cyc;
      have_prev = 1;
    end else begin
      check("data_hold", 32'(bus.data_o), 32'(last_data));
    end
    prev_valid = bus.valid_o;
    check("empty", 32'(bus.empty_o), 32'(m_count == 0));
    check("full",  32'(bus.full_o),  32'(m_count == DEPTH));
    check("ready", 32'(bus.ready_o), 32'(m_count != DEPTH));
    if (m_count == DEPTH) saw_full = 1;
  endtask

  task automatic step(input bit s, input logic [7:0] d);
    bit acc;
    bus.send_i = s;
    bus.data_i = d;
    acc = s && (m_count < DEPTH);
    if (acc) sb.push_back(d);
    else if (s) rejected++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (acc) begin
      m_count++;
      acc_cyc = cyc;
    end
    monitor();
    bus.send_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step(0, 8'h00);
      n++;
    end
    check("drain_complete", 32'(sb.size()), 32'd0);
    repeat (GAP + 3) step(0, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.valid_o),    32'd0);
    check({tag, "_data"},  32'(bus.data_o),     32'd0);
    check({tag, "_tx"},    32'(bus.tx_count_o), 32'd0);
    check({tag, "_empty"}, 32'(bus.empty_o),    32'd1);
    check({tag, "_full"},  32'(bus.full_o),     32'd0);
    check({tag, "_ready"}, 32'(bus.ready_o),    32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    bus.send_i = 1'b0;
    bus.data_i = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    resetn = 1'b1;
    repeat (2) step(0, 8'h00);

    // single byte with 2-edge latency
    step(1, 8'hA5);
    drain(50);
    check("single_latency", 32'(prev_cyc - acc_cyc), 32'd1);
    check("single_data", 32'(bus.data_o), 32'hA5);
    check("single_tx", 32'(bus.tx_count_o), 32'd1);
    check("single_empty", 32'(bus.empty_o), 32'd1);

    // burst 01..04, pops keep pace
    saw_full = 0;
    for (int i = 1; i <= 4; i++) step(1, 8'(i));
    drain(100);
    check("burst_no_full", 32'(saw_full), 32'd0);

    // overrun: continuous offers must fill the FIFO and reject some bytes
    saw_full = 0;
    rejected = 0;
    for (int i = 0; i < 10; i++) step(1, 8'h10 + 8'(i));
    check("overrun_full_seen", 32'(saw_full), 32'd1);
    check("overrun_rejected", 32'(rejected > 0), 32'd1);
    drain(100);

    // random traffic
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 8'($urandom));
    drain(200);

    // reset with 3 bytes queued
    for (int i = 0; i < 4; i++) step(1, 8'hC0 + 8'(i));
    check("queued_before_reset", 32'(m_count), 32'd3);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("mid_reset");
    sb.delete();
    m_count = 0;
    exp_tx = 4'd0;
    last_data = 8'd0;
    have_prev = 0;
    prev_valid = 0;
    repeat (3) begin
      @(negedge clk);
      check("valid_in_reset", 32'(bus.valid_o), 32'd0);
    end
    resetn = 1'b1;
    repeat (6) step(0, 8'h00);
    step(1, 8'h3C);
    drain(50);
    check("post_reset_latency", 32'(prev_cyc - acc_cyc), 32'd1);
    check("post_reset_tx", 32'(bus.tx_count_o), 32'd1);

    // 16 more bytes: 17 since reset, counter wraps to 1
    sent = 0;
    while (sent < 16) begin
      if (m_count < DEPTH) begin
        step(1, 8'h40 + 8'(sent));
        sent++;
      end else begin
        step(0, 8'h00);
      end
    end
    drain(200);
    check("wrap_tx", 32'(bus.tx_count_o), 32'd1);
    check("wrap_empty", 32'(bus.empty_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
